twiddle_fetch: RTL and testbench
================================

# twiddle_fetch

Consumer end of the twiddle-address stream. Accepts twiddle indices k (0..N/2-1), such as those produced by the twiddle address sequencer, and reads a dual-port quarter-wave cosine ROM that holds only N/4+1 entries. It rebuilds the full complex twiddle factor W_N^k = cos(2πk/N) − j·sin(2πk/N) using quadrant symmetry. It delivers the result to the butterfly datapath over a valid/ready handshake and flags the end of each full FFT frame of twiddles.

## Interface
Parameters:
- LOG_NBY2, default 3: log2(N/2); N = 2^(LOG_NBY2+1) (default N=16).
- DATA_W, default 16: two's-complement width of ROM words and outputs.

Ports:
- pulse  in  1  clock; every register updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- w_add  in  LOG_NBY2  twiddle index k.
- w_valid  in  1  w_add is valid.
- w_ready  out  1  block can accept w_add this cycle.
- rom_en  out  1  ROM read enable, both ports.
- rom_add_a  out  LOG_NBY2  ROM port A address (0..N/4).
- rom_add_b  out  LOG_NBY2  ROM port B address (0..N/4).
- rom_data_a  in  DATA_W  C[rom_add_a]. Synchronous ROM: data appears 1 edge after rom_en; the ROM holds its data while rom_en=0.
- rom_data_b  in  DATA_W  C[rom_add_b], same timing.
- w_re  out  DATA_W  real part of W_N^k.
- w_im  out  DATA_W  imaginary part of W_N^k.
- out_valid  out  1  w_re/w_im are valid.
- out_ready  in  1  downstream accepts the output.
- frame_done  out  1  one-cycle pulse at the end of each frame.

## Operation
- ROM content: C[m] = round(cos(2πm/N)·(2^(DATA_W−1)−1)) for m=0..N/4. All entries are ≥0.
- Quadrant decode, with Q=N/4 and k = w_add:
  - k<Q: rom_add_a=k, rom_add_b=Q−k; w_re=+data_a, w_im=−data_b.
  - k≥Q, r=k−Q: rom_add_a=r, rom_add_b=Q−r; w_re=−data_b, w_im=−data_a.
- Negation is plain two's-complement. It cannot overflow because ROM entries are non-negative. −0 yields 0.
- ROM addresses are combinational from w_add and computed at LOG_NBY2 width. Q−k is at most Q and always fits.
- Pipeline:
  - Stage 1 holds s1_valid and the quadrant bit q1 (k≥Q), aligned with ROM data.
  - Stage 2 is the output register (w_re, w_im, out_valid).
- Stall rule: stall = out_valid & ~out_ready.
  - w_ready = ~stall.
  - rom_en = w_valid & w_ready.
  - During stall, stage 1, stage 2 and the ROM outputs all hold.
- When not stalled, on each edge:
  - s1_valid ← w_valid.
  - q1 ← quadrant of w_add.
  - Stage 2 loads the decoded values of stage 1, and out_valid ← s1_valid.
  - If s1_valid=0, w_re/w_im keep their old values and out_valid drops.
- Frame counter: counts output transfers (out_valid & out_ready) from 0 to F−1, where F=(LOG_NBY2+1)·2^LOG_NBY2 (32 for N=16).
  - On the transfer that brings the count to F, the counter wraps to 0.
  - frame_done is high for exactly the following cycle.
- Indices need not follow any order. The block does not check the sequence; it only counts transfers.

## Timing
- Reset values: w_re=0, w_im=0, out_valid=0, frame_done=0, s1_valid=0, q1=0, frame counter=0. With reset high, w_ready=1 and rom_en=w_valid (combinational); nothing is captured.
- Reset asserted mid-operation: all in-flight twiddles are discarded and the frame count restarts from 0.
- Latency: a handshake at edge t puts the result on the outputs after edge t+1, with out_valid high.
- Throughput: 1 twiddle per cycle with out_ready held high.
- Backpressure: when out_ready=0 with out_valid=1, w_ready falls combinationally the same cycle. No data is lost or duplicated. Stage-1 data survives an arbitrarily long stall.
- Simultaneous output transfer and new input: both occur on the same edge (no bubble).

## Test plan
- N=16, DATA_W=16, ROM C={32767,30273,23170,12539,0}.
  - Drive k=0..7 back to back with out_ready=1. Required outputs, 2 cycles after each input:
    - k=0: (32767, 0); k=1: (30273, −12539); k=2: (23170, −23170); k=3: (12539, −30273).
    - k=4: (0, −32767); k=5: (−12539, −30273); k=6: (−23170, −23170); k=7: (−30273, −12539).
- Stall: drop out_ready for 5 cycles while k=5 is in stage 2 and k=6 is in stage 1.
  - w_ready=0 and rom_en=0 throughout the stall.
  - After release, the outputs are exactly 5, then 6, then the following indices; no duplicates.
- Frame: send the 32-index sequence from the address sequencer with out_ready=1.
  - frame_done pulses once, 1 cycle after the 32nd output transfer; the counter returns to 0.
  - A second frame pulses again after 32 more transfers.
- Bubbles: insert w_valid=0 gaps. out_valid shows matching gaps and w_re/w_im hold their last value.
- Reset mid-stream: assert reset with 2 twiddles in flight.
  - All outputs go to 0 immediately and no stale output appears afterwards.
  - A subsequent full frame gives frame_done after 32 transfers.

Source files
------------

// File: rtl/twiddle_fetch_if.sv
// twiddle_fetch_if: groups the index stream, ROM read bus and twiddle output stream.
//   w_add/w_valid/w_ready         : twiddle index handshake (producer -> fetch)
//   rom_en/rom_add_a/rom_add_b    : dual-port quarter-wave cosine ROM request
//   rom_data_a/rom_data_b         : ROM read data, one edge after rom_en
//   w_re/w_im/out_valid/out_ready : complex twiddle handshake (fetch -> butterfly)
//   frame_done                    : one-cycle end-of-frame pulse
// slave is the fetch block's view; master is the surrounding environment
// (index source, ROM and butterfly sink).
interface twiddle_fetch_if #(
  parameter int unsigned LOG_NBY2 = 3,
  parameter int unsigned DATA_W   = 16
);
  logic [LOG_NBY2-1:0] w_add;
  logic                w_valid;
  logic                w_ready;
  logic                rom_en;
  logic [LOG_NBY2-1:0] rom_add_a;
  logic [LOG_NBY2-1:0] rom_add_b;
  logic [DATA_W-1:0]   rom_data_a;
  logic [DATA_W-1:0]   rom_data_b;
  logic [DATA_W-1:0]   w_re;
  logic [DATA_W-1:0]   w_im;
  logic                out_valid;
  logic                out_ready;
  logic                frame_done;

  modport slave (
    input  w_add, w_valid, rom_data_a, rom_data_b, out_ready,
    output w_ready, rom_en, rom_add_a, rom_add_b, w_re, w_im, out_valid, frame_done
  );

  modport master (
    output w_add, w_valid, rom_data_a, rom_data_b, out_ready,
    input  w_ready, rom_en, rom_add_a, rom_add_b, w_re, w_im, out_valid, frame_done
  );
endinterface

// File: rtl/twiddle_fetch.sv
// twiddle_fetch: turns twiddle indices k (0..N/2-1) into W_N^k = cos - j*sin by
// reading a quarter-wave cosine ROM (N/4+1 entries) and applying quadrant symmetry.
// Ports:
//   pulse : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : twiddle_fetch_if.slave (index in, ROM bus, twiddle out, frame_done)
// Pipeline: ROM read + stage 1 (s1_valid, q1) -> stage 2 output register.
// Whole pipeline freezes while the output is valid and not accepted.
module twiddle_fetch #(
  parameter int unsigned LOG_NBY2 = 3,
  parameter int unsigned DATA_W   = 16
) (
  input  logic            pulse,
  input  logic            reset,
  twiddle_fetch_if.slave  bus
);

  localparam int unsigned QTR   = 1 << (LOG_NBY2 - 1);
  localparam int unsigned FRAME = (LOG_NBY2 + 1) << LOG_NBY2;
  localparam int unsigned CNT_W = $clog2(FRAME);

  logic                s1_valid_q, s1_valid_d;
  logic                q1_q, q1_d;
  logic [DATA_W-1:0]   re_q, re_d;
  logic [DATA_W-1:0]   im_q, im_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                frame_done_q, frame_done_d;

  logic                stall_c;
  logic                quad_c;
  logic [LOG_NBY2-1:0] r_c;
  logic [DATA_W-1:0]   neg_a_c, neg_b_c;
  logic [DATA_W-1:0]   re_dec_c, im_dec_c;

  // Quadrant fold: second quadrant reuses the first with sin/cos swapped.
  always_comb begin
    quad_c = bus.w_add[LOG_NBY2-1];
    r_c    = quad_c ? bus.w_add - LOG_NBY2'(QTR) : bus.w_add;
  end

  assign bus.rom_add_a = r_c;
  assign bus.rom_add_b = LOG_NBY2'(QTR) - r_c;

  assign stall_c     = out_valid_q & ~bus.out_ready;
  assign bus.w_ready = ~stall_c;
  assign bus.rom_en  = bus.w_valid & ~stall_c;

  // ROM words are non-negative, so negation never overflows.
  always_comb begin
    neg_a_c  = DATA_W'(0) - bus.rom_data_a;
    neg_b_c  = DATA_W'(0) - bus.rom_data_b;
    re_dec_c = q1_q ? neg_b_c : bus.rom_data_a;
    im_dec_c = q1_q ? neg_a_c : neg_b_c;
  end

  // Next-state: pipeline advance and frame counting.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    q1_d         = q1_q;
    re_d         = re_q;
    im_d         = im_q;
    out_valid_d  = out_valid_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;

    if (!stall_c) begin
      s1_valid_d  = bus.w_valid;
      q1_d        = quad_c;
      out_valid_d = s1_valid_q;
      // Bubbles keep the previous twiddle on the data outputs.
      if (s1_valid_q) begin
        re_d = re_dec_c;
        im_d = im_dec_c;
      end
    end

    if (out_valid_q && bus.out_ready) begin
      if (cnt_q == CNT_W'(FRAME - 1)) begin
        cnt_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge pulse or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      q1_q         <= 1'b0;
      re_q         <= '0;
      im_q         <= '0;
      out_valid_q  <= 1'b0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      q1_q         <= q1_d;
      re_q         <= re_d;
      im_q         <= im_d;
      out_valid_q  <= out_valid_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.w_re       = re_q;
  assign bus.w_im       = im_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_twiddle_fetch.sv
// tb_twiddle_fetch: directed stimulus for twiddle_fetch (N=16, DATA_W=16) with a
// trigonometric reference model, a per-cycle output monitor and literal pins.
module tb_twiddle_fetch;

  localparam int unsigned LOG_NBY2 = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int          NPTS     = 16;
  localparam int          FRAME    = 32;
  localparam real         PI       = 3.14159265358979323846;

  logic pulse = 1'b0;
  logic reset = 1'b0;

  twiddle_fetch_if #(.LOG_NBY2(LOG_NBY2), .DATA_W(DATA_W)) bus ();

  twiddle_fetch #(.LOG_NBY2(LOG_NBY2), .DATA_W(DATA_W)) dut (
    .pulse (pulse),
    .reset (reset),
    .bus   (bus)
  );

  always #5 pulse = ~pulse;

  // Quarter-wave cosine ROM, synchronous read, holds while disabled.
  int unsigned rom_tbl [5] = '{32767, 30273, 23170, 12539, 0};
  logic [DATA_W-1:0] rom_a_q = '0;
  logic [DATA_W-1:0] rom_b_q = '0;
  always @(posedge pulse) begin
    if (bus.rom_en) begin
      rom_a_q <= DATA_W'(rom_tbl[int'(bus.rom_add_a)]);
      rom_b_q <= DATA_W'(rom_tbl[int'(bus.rom_add_b)]);
    end
  end
  assign bus.rom_data_a = rom_a_q;
  assign bus.rom_data_b = rom_b_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: W_N^k straight from cos/sin, rounded to the ROM scale.
  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction
  function automatic int model_re(input int k);
    return rnd($cos(2.0 * PI * k / NPTS) * 32767.0);
  endfunction
  function automatic int model_im(input int k);
    return -rnd($sin(2.0 * PI * k / NPTS) * 32767.0);
  endfunction

  typedef struct { int k; int cyc; } item_t;
  item_t sb[$];
  int    log_re[$];
  int    log_im[$];
  int    log_dly[$];
  int    cyc     = 0;
  int    fcnt    = 0;
  int    fd_seen = 0;
  int    last_re = 0;
  int    last_im = 0;
  logic  fd_pend = 1'b0;
  logic  fd_next;
  logic  wr_exp;
  int    er, ei;

  // Monitor: sampled mid-cycle, checks every cycle against the model.
  always @(negedge pulse) begin
    if (reset) begin
      check("rst_w_re", $signed(bus.w_re), 0);
      check("rst_w_im", $signed(bus.w_im), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_frame_done", int'(bus.frame_done), 0);
      check("rst_w_ready", int'(bus.w_ready), 1);
      check("rst_rom_en", int'(bus.rom_en), int'(bus.w_valid));
      sb.delete();
      fcnt    = 0;
      fd_pend = 1'b0;
      last_re = 0;
      last_im = 0;
    end else begin
      check("frame_done", int'(bus.frame_done), int'(fd_pend));
      if (bus.frame_done) fd_seen++;
      wr_exp = !(bus.out_valid && !bus.out_ready);
      check("w_ready", int'(bus.w_ready), int'(wr_exp));
      check("rom_en", int'(bus.rom_en), int'(bus.w_valid && wr_exp));
      fd_next = 1'b0;
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stale_out: out_valid=1 with nothing in flight, w_re=%0d (t=%0t)",
                   $signed(bus.w_re), $time);
        end else begin
          er = model_re(sb[0].k);
          ei = model_im(sb[0].k);
          check("w_re", $signed(bus.w_re), er);
          check("w_im", $signed(bus.w_im), ei);
          last_re = er;
          last_im = ei;
          if (bus.out_ready) begin
            log_re.push_back($signed(bus.w_re));
            log_im.push_back($signed(bus.w_im));
            log_dly.push_back(cyc - sb[0].cyc);
            void'(sb.pop_front());
            fd_next = (fcnt == FRAME - 1);
            fcnt    = (fcnt + 1) % FRAME;
          end
        end
      end else begin
        check("hold_re", $signed(bus.w_re), last_re);
        check("hold_im", $signed(bus.w_im), last_im);
      end
      fd_pend = fd_next;
      if (bus.w_valid && wr_exp) sb.push_back('{k: int'(bus.w_add), cyc: cyc});
    end
    cyc++;
  end

  // Driver: inputs change just after the rising edge.
  logic acc_s, wr_s, re_s;
  task automatic step(input logic v, input int k, input logic ordy);
    bus.w_valid   = v;
    bus.w_add     = LOG_NBY2'(k);
    bus.out_ready = ordy;
    @(negedge pulse);
    acc_s = v && bus.w_ready;
    wr_s  = bus.w_ready;
    re_s  = bus.rom_en;
    @(posedge pulse);
    #1;
  endtask

  task automatic send(input int k);
    int tries = 0;
    do begin
      step(1'b1, k, 1'b1);
      tries++;
    end while (!acc_s && tries < 20);
    if (!acc_s) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: k=%0d not accepted within 20 cycles", k);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1);
  endtask

  int lit_re [8] = '{32767, 30273, 23170, 12539, 0, -12539, -23170, -30273};
  int lit_im [8] = '{0, -12539, -23170, -30273, -32767, -30273, -23170, -12539};
  int seq    [32];
  int base;

  initial begin
    bus.w_valid   = 1'b0;
    bus.w_add     = '0;
    bus.out_ready = 1'b1;
    #1 reset = 1'b1;
    repeat (3) @(posedge pulse);
    #1 reset = 1'b0;

    for (int s = 0; s < 4; s++)
      for (int j = 0; j < 8; j++) seq[s*8 + j] = (j << s) % 8;

    // Back-to-back k=0..7, fixed two-edge latency.
    base = log_re.size();
    for (int k = 0; k < 8; k++) send(k);
    idle(4);
    check("p1_count", log_re.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < log_re.size()) begin
        check($sformatf("p1_re_k%0d", i), log_re[base+i], lit_re[i]);
        check($sformatf("p1_im_k%0d", i), log_im[base+i], lit_im[i]);
        check($sformatf("p1_lat_k%0d", i), log_dly[base+i], 2);
      end
    end

    // Stall with k=5 in stage 2 and k=6 in stage 1.
    base = log_re.size();
    for (int k = 0; k < 7; k++) send(k);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 7, 1'b0);
      check("stall_w_ready", int'(wr_s), 0);
      check("stall_rom_en", int'(re_s), 0);
    end
    send(7);
    idle(4);
    check("p2_count", log_re.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < log_re.size()) begin
        check($sformatf("p2_re_k%0d", i), log_re[base+i], lit_re[i]);
        check($sformatf("p2_im_k%0d", i), log_im[base+i], lit_im[i]);
      end
    end
    check("no_early_frame_done", fd_seen, 0);

    // Clean reset, then two frames (second with bubbles).
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    for (int i = 0; i < 31; i++) send(seq[i]);
    idle(3);
    check("frame1_before_last", fd_seen, 0);
    send(seq[31]);
    idle(4);
    check("frame1_done", fd_seen, 1);
    for (int i = 0; i < 32; i++) begin
      send(seq[i]);
      if (i % 3 == 0) idle(2);
    end
    idle(4);
    check("frame2_done", fd_seen, 2);

    // Reset with two twiddles in flight and a partial frame count.
    for (int k = 0; k < 5; k++) send(k);
    send(3);
    send(6);
    reset = 1'b1;
    #1;
    check("midrst_w_re", $signed(bus.w_re), 0);
    check("midrst_w_im", $signed(bus.w_im), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    idle(2);
    reset = 1'b0;
    idle(3);
    for (int i = 0; i < 32; i++) send(seq[i]);
    idle(4);
    check("frame3_done", fd_seen, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
